// File: rtl/csram_loader.sv
// csram_loader: packs a valid/ready byte stream into WIDTH-bit neuron words and
// writes them to the CSRAM at consecutive addresses, from start_address up to
// the last neuron.
//
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   start                one-cycle pulse that begins or restarts a load
//   start_address        first neuron address, sampled with start
//   byte_in, byte_valid  incoming configuration byte and its valid flag
//   byte_ready           loader takes a byte this cycle
//   csram_wen            one-cycle CSRAM write strobe
//   csram_address        CSRAM write address
//   csram_data           CSRAM write data
//   busy                 a load is in progress
//   done                 last word written; held until the next start
module csram_loader #(
   parameter int unsigned NUM_NEURONS = 256,
   parameter int unsigned WIDTH       = 367
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [$clog2(NUM_NEURONS)-1:0] start_address,
   input  logic [7:0]                     byte_in,
   input  logic                           byte_valid,
   output logic                           byte_ready,
   output logic                           csram_wen,
   output logic [$clog2(NUM_NEURONS)-1:0] csram_address,
   output logic [WIDTH-1:0]               csram_data,
   output logic                           busy,
   output logic                           done
);

   localparam int unsigned NUM_BYTES = (WIDTH + 7) / 8;
   localparam int unsigned AW        = $clog2(NUM_NEURONS);
   localparam int unsigned CW        = $clog2(NUM_BYTES);
   // The partial register holds every byte of a word except the final one.
   localparam int unsigned PW        = (NUM_BYTES - 1) * 8;

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   part_q, part_d;
   logic [PW+7:0]   full_c;
   logic            accept_c, last_byte_c, last_addr_c, start_ok_c;
   logic            byte_ready_d, csram_wen_d, busy_d, done_d;
   logic [AW-1:0]   csram_address_d;
   logic [WIDTH-1:0] csram_data_d;

   // Bytes enter at the top and shift down, so byte k ends at bits [8k+7:8k].
   assign full_c      = {byte_in, part_q};
   // byte_ready is registered, so a coincident start masks the handshake here.
   assign accept_c    = byte_valid & byte_ready & ~start;
   assign last_byte_c = accept_c & (cnt_q == CW'(NUM_BYTES - 1));
   assign last_addr_c = (addr_q == AW'(NUM_NEURONS - 1));
   assign start_ok_c  = (32'(start_address) < NUM_NEURONS);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; start overrides every state
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = start_ok_c ? COLLECT : DONE;
      end else begin
         case (state_q)
            COLLECT: if (last_byte_c) state_d = WRITE;
            WRITE:   state_d = last_addr_c ? DONE : COLLECT;
            default: state_d = state_q;
         endcase
      end
   end

   // Next values for datapath registers and registered outputs
   always_comb begin
      addr_d          = addr_q;
      cnt_d           = cnt_q;
      part_d          = part_q;
      byte_ready_d    = (state_d == COLLECT);
      csram_wen_d     = (state_d == WRITE);
      busy_d          = (state_d == COLLECT) || (state_d == WRITE);
      done_d          = (state_d == DONE);
      csram_address_d = csram_address;
      csram_data_d    = csram_data;
      if (start) begin
         if (start_ok_c) addr_d = start_address;
         cnt_d  = '0;
         part_d = '0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (accept_c) begin
                  part_d = full_c[PW+7:8];
                  cnt_d  = last_byte_c ? '0 : cnt_q + CW'(1);
               end
            end
            WRITE: begin
               if (!last_addr_c) addr_d = addr_q + AW'(1);
               cnt_d = '0;
            end
            default: ;
         endcase
      end
      // Data and address move only when a word completes.
      if (csram_wen_d) begin
         csram_address_d = addr_q;
         csram_data_d    = full_c[WIDTH-1:0];
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q        <= '0;
         cnt_q         <= '0;
         part_q        <= '0;
         byte_ready    <= 1'b0;
         csram_wen     <= 1'b0;
         csram_address <= '0;
         csram_data    <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         addr_q        <= addr_d;
         cnt_q         <= cnt_d;
         part_q        <= part_d;
         byte_ready    <= byte_ready_d;
         csram_wen     <= csram_wen_d;
         csram_address <= csram_address_d;
         csram_data    <= csram_data_d;
         busy          <= busy_d;
         done          <= done_d;
      end
   end

endmodule

// File: tb/tb_csram_loader.sv
// Directed bench for csram_loader: a table of load scenarios plus hand-written
// sequences for restart, start/byte collision and reset during a write.
module tb_csram_loader;

   localparam int unsigned NUM_NEURONS = 256;
   localparam int unsigned WIDTH       = 367;
   localparam int unsigned NB          = 46;
   localparam int unsigned AW          = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [AW-1:0]    start_address = '0;
   logic [7:0]       byte_in = '0;
   logic             byte_valid = 1'b0;
   logic             byte_ready, csram_wen, busy, done;
   logic [AW-1:0]    csram_address;
   logic [WIDTH-1:0] csram_data;

   int n_vec = 0;
   int n_bad = 0;

   logic [AW+WIDTH-1:0] wr_q[$];

   csram_loader #(.NUM_NEURONS(NUM_NEURONS), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .start(start), .start_address(start_address),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .csram_wen(csram_wen), .csram_address(csram_address),
      .csram_data(csram_data), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   addr;
      int   kind;
      int   nbytes;
      int   gap;
      int   exp_writes;
      logic exp_done;
      logic exp_busy;
      logic exp_ready;
      int   extra_valid;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_word(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int kind, input int j);
      case (kind)
         0:       pat = 8'(j);
         1:       pat = 8'hFF;
         2:       pat = 8'(j * 7 + 3);
         default: pat = 8'hAA;
      endcase
   endfunction

   // Reference word: byte k at bits [8k+7:8k], top bit of the last byte dropped.
   function automatic logic [WIDTH-1:0] build_word(input int kind, input int widx);
      logic [NB*8-1:0] w;
      w = '0;
      for (int k = 0; k < NB; k++) w[8*k +: 8] = pat(kind, widx * NB + k);
      build_word = w[WIDTH-1:0];
   endfunction

   // Capture every write strobe; byte_ready must be low while writing.
   always @(negedge clk) begin
      if (csram_wen === 1'b1) begin
         wr_q.push_back({csram_address, csram_data});
         chk("ready_during_write", 64'(byte_ready), 64'd0);
      end
   end

   // Called at a negedge; returns at the negedge after the byte was taken.
   task automatic send_byte(input logic [7:0] b);
      int budget;
      bit taken;
      budget = 200;
      taken  = 1'b0;
      byte_in    = b;
      byte_valid = 1'b1;
      while (!taken && budget > 0) begin
         taken = (byte_ready === 1'b1);
         @(negedge clk);
         budget--;
      end
      byte_valid = 1'b0;
      if (!taken) begin
         n_vec++;
         n_bad++;
         $display("FAIL send_byte: byte_ready stayed %b, required 1 within 200 cycles", byte_ready);
      end
   endtask

   task automatic send_seq(input int kind, input int j0, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         send_byte(pat(kind, j0 + i));
         if (gap > 0 && (i % gap) == gap - 1) @(negedge clk);
      end
   endtask

   task automatic pulse_start(input int a);
      start         = 1'b1;
      start_address = AW'(a);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic chk_one_write(input string name, input int a, input int kind);
      logic [AW+WIDTH-1:0] w;
      chk({name, "_count"}, 64'(wr_q.size()), 64'd1);
      if (wr_q.size() > 0) begin
         w = wr_q.pop_front();
         chk({name, "_addr"}, 64'(w[AW+WIDTH-1:WIDTH]), 64'(a));
         chk_word({name, "_data"}, w[WIDTH-1:0], build_word(kind, 0));
      end
      wr_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [AW+WIDTH-1:0] w;
      logic [WIDTH-1:0]    ones;
      ones = '1;

      tbl[0] = '{0,   0, 46,  0, 1, 1'b0, 1'b1, 1'b1, 0};
      tbl[1] = '{254, 1, 92,  0, 2, 1'b1, 1'b0, 1'b0, 1};
      tbl[2] = '{10,  0, 46,  3, 1, 1'b0, 1'b1, 1'b1, 0};
      tbl[3] = '{100, 2, 46,  0, 1, 1'b0, 1'b1, 1'b1, 0};
      tbl[4] = '{200, 2, 138, 2, 3, 1'b0, 1'b1, 1'b1, 0};

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_ready", 64'(byte_ready), 64'd0);
      chk("rst_wen", 64'(csram_wen), 64'd0);
      chk("rst_addr", 64'(csram_address), 64'd0);
      chk_word("rst_data", csram_data, '0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", 64'(byte_ready), 64'd0);

      // Table-driven loads
      for (int v = 0; v < 5; v++) begin
         wr_q.delete();
         pulse_start(tbl[v].addr);
         send_seq(tbl[v].kind, 0, tbl[v].nbytes, tbl[v].gap);
         repeat (3) @(negedge clk);
         chk($sformatf("v%0d_writes", v), 64'(wr_q.size()), 64'(tbl[v].exp_writes));
         for (int i = 0; i < tbl[v].exp_writes && wr_q.size() > 0; i++) begin
            w = wr_q.pop_front();
            chk($sformatf("v%0d_w%0d_addr", v, i), 64'(w[AW+WIDTH-1:WIDTH]), 64'(tbl[v].addr + i));
            chk_word($sformatf("v%0d_w%0d_data", v, i), w[WIDTH-1:0], build_word(tbl[v].kind, i));
            if (v == 0 && i == 0) begin
               chk("v0_byte0", 64'(w[7:0]), 64'h00);
               chk("v0_byte1", 64'(w[15:8]), 64'h01);
               chk("v0_top7", 64'(w[366:360]), 64'h2D);
            end
            if (v == 1) chk_word($sformatf("v1_w%0d_ones", i), w[WIDTH-1:0], ones);
         end
         chk($sformatf("v%0d_done", v), 64'(done), 64'(tbl[v].exp_done));
         chk($sformatf("v%0d_busy", v), 64'(busy), 64'(tbl[v].exp_busy));
         chk($sformatf("v%0d_ready", v), 64'(byte_ready), 64'(tbl[v].exp_ready));
         if (tbl[v].extra_valid != 0) begin
            wr_q.delete();
            byte_valid = 1'b1;
            byte_in    = 8'h12;
            repeat (5) @(negedge clk);
            byte_valid = 1'b0;
            chk("done_ignore_ready", 64'(byte_ready), 64'd0);
            chk("done_ignore_writes", 64'(wr_q.size()), 64'd0);
            chk("done_hold", 64'(done), 64'd1);
         end
      end

      // Restart after 20 bytes: partial word discarded
      wr_q.delete();
      pulse_start(30);
      send_seq(3, 0, 20, 0);
      pulse_start(5);
      chk("restart_done_clear", 64'(done), 64'd0);
      send_seq(0, 0, 46, 0);
      repeat (3) @(negedge clk);
      chk_one_write("restart", 5, 0);

      // start with a simultaneous byte handshake: the byte is not counted
      pulse_start(40);
      send_seq(3, 0, 10, 0);
      start         = 1'b1;
      start_address = AW'(41);
      byte_in       = 8'hEE;
      byte_valid    = 1'b1;
      chk("collide_ready_pre", 64'(byte_ready), 64'd1);
      @(negedge clk);
      start      = 1'b0;
      byte_valid = 1'b0;
      wr_q.delete();
      send_seq(0, 0, 45, 0);
      repeat (3) @(negedge clk);
      chk("collide_no_early_write", 64'(wr_q.size()), 64'd0);
      send_byte(pat(0, 45));
      repeat (2) @(negedge clk);
      chk_one_write("collide", 41, 0);

      // Reset asserted in the middle of the WRITE cycle
      pulse_start(60);
      send_seq(0, 0, 45, 0);
      byte_in    = pat(0, 45);
      byte_valid = 1'b1;
      @(posedge clk);
      #2;
      byte_valid = 1'b0;
      chk("mid_wen_before_rst", 64'(csram_wen), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_wen", 64'(csram_wen), 64'd0);
      chk("mid_rst_addr", 64'(csram_address), 64'd0);
      chk_word("mid_rst_data", csram_data, '0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      chk("mid_rst_ready", 64'(byte_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_idle_ready", 64'(byte_ready), 64'd0);
      chk("mid_rst_no_write", 64'(wr_q.size()), 64'd0);
      wr_q.delete();
      pulse_start(61);
      send_seq(0, 0, 46, 0);
      repeat (3) @(negedge clk);
      chk_one_write("post_rst", 61, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
